// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame constants and the
// odd-parity helper also used by receiver-side checks.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BIT  = 2'd2,
      GAP  = 2'd3
   } ps2_state_e;

   localparam int   PS2_FRAME_BITS = 11;
   localparam logic PS2_START      = 1'b0;
   localparam logic PS2_STOP       = 1'b1;

   // Odd parity: data ones plus parity bit is always odd.
   function automatic logic ps2_odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   // Wire order is bit 0 first: start, d[0..7], parity, stop.
   function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
      return {PS2_STOP, ps2_odd_parity(d), d, PS2_START};
   endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO feeding the PS/2 transmitter. Pushes while full and pops while
// empty are ignored; reset discards all contents.
module ps2_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_sender.sv
// Device-side PS/2 transmitter: buffers scan-code bytes and serialises each
// into an 11-bit frame while generating ps2_clk itself.
//
// state | meaning
// IDLE  | lines high, waiting for a buffered byte
// LOAD  | pop FIFO, latch frame, drive start bit
// BIT   | one bit per period: CLK_HALF cycles clk high, CLK_HALF low
// GAP   | lines high for GAP_CYCLES after the stop bit
module ps2_sender
   import ps2_pkg::*;
#(
   parameter int CLK_HALF   = 50,
   parameter int GAP_CYCLES = 200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy
);

   localparam int HW = $clog2(CLK_HALF);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_HALF - 1);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
   localparam logic [3:0]    LAST_IDX  = 4'(PS2_FRAME_BITS - 1);

   ps2_state_e                  state_q;
   logic [HW-1:0]               half_q;
   logic                        low_half_q;
   logic [3:0]                  idx_q;
   logic [GW-1:0]               gap_q;
   logic [PS2_FRAME_BITS-1:0]   shift_q;
   logic [PS2_FRAME_BITS-1:0]   frame_d;
   logic                        ps2_clk_q;
   logic                        ps2_data_q;

   logic                        fifo_full;
   logic                        fifo_empty;
   logic [7:0]                  fifo_rdata;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   ps2_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (resetn),
      .push_i  (in_valid),
      .wdata_i (in_data),
      .pop_i   (state_q == LOAD),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign frame_d  = ps2_frame(fifo_rdata);
   assign in_ready = !fifo_full;
   assign busy     = (state_q != IDLE) || (fifo_count != '0);
   assign ps2_clk  = ps2_clk_q;
   assign ps2_data = ps2_data_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         half_q     <= '0;
         low_half_q <= 1'b0;
         idx_q      <= '0;
         gap_q      <= '0;
         shift_q    <= '1;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               // Bit 0 goes straight to the line; the rest waits in shift_q.
               ps2_data_q <= frame_d[0];
               shift_q    <= {1'b1, frame_d[PS2_FRAME_BITS-1:1]};
               ps2_clk_q  <= 1'b1;
               idx_q      <= '0;
               half_q     <= HALF_LOAD;
               low_half_q <= 1'b0;
               state_q    <= BIT;
            end
            BIT: begin
               if (half_q != '0) begin
                  half_q <= half_q - 1'b1;
               end else if (!low_half_q) begin
                  ps2_clk_q  <= 1'b0;
                  low_half_q <= 1'b1;
                  half_q     <= HALF_LOAD;
               end else if (idx_q == LAST_IDX) begin
                  ps2_clk_q  <= 1'b1;
                  ps2_data_q <= 1'b1;
                  gap_q      <= GAP_LOAD;
                  state_q    <= GAP;
               end else begin
                  // Data moves together with the rising clock edge only.
                  ps2_clk_q  <= 1'b1;
                  ps2_data_q <= shift_q[0];
                  shift_q    <= {1'b1, shift_q[PS2_FRAME_BITS-1:1]};
                  idx_q      <= idx_q + 1'b1;
                  low_half_q <= 1'b0;
                  half_q     <= HALF_LOAD;
               end
            end
            GAP: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end else if (fifo_empty) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= LOAD;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
